// File: rtl/tbus_sink_arbiter_pkg.sv
// rtl/tbus_sink_arbiter_pkg.sv - shared constants and helpers for the tri-state bus sink arbiter
package tbus_sink_arbiter_pkg;

    localparam int C_FIFO_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tbus_sink_fifo.sv
// rtl/tbus_sink_fifo.sv - 2-entry first-in first-out buffer with registered head and async clear
module tbus_sink_fifo
    import tbus_sink_arbiter_pkg::*;
#(
    parameter int C_DW = 18
) (
    input  logic            CLK,
    input  logic            ACLR_N,
    input  logic            i_wr_valid,
    input  logic [C_DW-1:0] i_wr_data,
    output logic [C_DW-1:0] o_rd_data,
    output logic            o_rd_valid,
    input  logic            i_rd_ready,
    output logic [1:0]      o_count
);

    logic [C_DW-1:0] r_d0;
    logic [C_DW-1:0] r_d1;
    logic [1:0]      r_count;
    logic            w_pop;

    assign w_pop      = (r_count != 2'd0) && i_rd_ready;
    assign o_rd_data  = r_d0;
    assign o_rd_valid = (r_count != 2'd0);
    assign o_count    = r_count;

    // r_d0 is always the head; a pop shifts r_d1 forward.
    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_count <= 2'd0;
        end else if (w_pop) begin
            if (i_wr_valid && r_count == 2'd1) begin
                r_d0 <= i_wr_data;
            end else begin
                r_d0    <= r_d1;
                r_count <= r_count - 2'd1;
            end
        end else if (i_wr_valid && r_count != 2'(C_FIFO_DEPTH)) begin
            if (r_count == 2'd0) r_d0 <= i_wr_data;
            else                 r_d1 <= i_wr_data;
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/tbus_sink_arbiter.sv
// rtl/tbus_sink_arbiter.sv - round-robin OE owner and capture sink for a shared tri-state bus
module tbus_sink_arbiter
    import tbus_sink_arbiter_pkg::*;
#(
    parameter int C_WIDTH      = 16,
    parameter int C_NUM_SRC    = 4,
    parameter int C_TURNAROUND = 1
) (
    input  logic                          CLK,
    input  logic                          ACLR_N,
    input  logic [C_NUM_SRC-1:0]          REQ,
    output logic [C_NUM_SRC-1:0]          OE,
    input  logic [C_WIDTH-1:0]            BUS,
    output logic [C_WIDTH-1:0]            O,
    output logic [clog2(C_NUM_SRC)-1:0]   O_SRC,
    output logic                          O_VALID,
    input  logic                          O_READY
);

    localparam int C_SW = clog2(C_NUM_SRC);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [C_NUM_SRC-1:0] r_oe;
    logic [C_SW-1:0]      r_g;
    logic [C_SW-1:0]      r_ptr;
    logic [C_SW-1:0]      r_last;
    logic                 r_last_vld;
    logic [1:0]           r_tcnt;
    logic [C_SW-1:0]      w_base;
    logic [C_SW-1:0]      w_idx;
    logic [C_SW-1:0]      w_win;
    logic                 w_any;
    logic                 w_space;
    logic                 w_owed;
    logic                 w_pop;
    logic                 w_drive;
    logic [1:0]           w_count;
    logic [2:0]           w_occ;
    logic [C_WIDTH+C_SW-1:0] w_rd_data;

    assign OE      = r_oe;
    assign w_drive = (r_state == ST_DRIVE);
    assign w_pop   = O_VALID && O_READY;

    // Occupancy after this edge; the word on the bus during DRIVE already claims a slot.
    assign w_occ   = {1'b0, w_count} + {2'b00, w_drive} - {2'b00, w_pop};
    assign w_space = (w_occ < 3'(C_FIFO_DEPTH));

    // While driving, the current grant is the round-robin base it will become at the edge.
    assign w_base = w_drive ? r_g : r_ptr;

    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= C_NUM_SRC; i++) begin
            w_idx = C_SW'((int'(w_base) + i) % C_NUM_SRC);
            if (!w_any && REQ[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // The current idle/turn cycle is itself dead time, so only more than one pending cycle is owed.
    assign w_owed = r_last_vld && (w_win != r_last) && (r_tcnt > 2'd1);

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_DRIVE: begin
                if (w_any && w_space) begin
                    if (w_win == r_g || C_TURNAROUND == 0) w_state_nxt = ST_DRIVE;
                    else                                   w_state_nxt = ST_TURN;
                end
            end
            ST_TURN: begin
                if (r_tcnt > 2'd1)          w_state_nxt = ST_TURN;
                else if (w_any && w_space)  w_state_nxt = ST_DRIVE;
            end
            default: begin
                if (w_any && w_space) w_state_nxt = w_owed ? ST_TURN : ST_DRIVE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            r_state    <= ST_IDLE;
            r_oe       <= '0;
            r_g        <= '0;
            r_ptr      <= C_SW'(C_NUM_SRC - 1);
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_tcnt     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_oe    <= (w_state_nxt == ST_DRIVE) ? (C_NUM_SRC'(1) << w_win) : '0;
            if (w_state_nxt == ST_DRIVE) r_g <= w_win;
            if (w_drive) begin
                r_ptr      <= r_g;
                r_last     <= r_g;
                r_last_vld <= 1'b1;
                r_tcnt     <= 2'(C_TURNAROUND);
            end else if (r_tcnt != 2'd0) begin
                r_tcnt <= r_tcnt - 2'd1;
            end
        end
    end

    tbus_sink_fifo #(
        .C_DW (C_WIDTH + C_SW)
    ) u_fifo (
        .CLK        (CLK),
        .ACLR_N     (ACLR_N),
        .i_wr_valid (w_drive),
        .i_wr_data  ({BUS, r_g}),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (O_VALID),
        .i_rd_ready (O_READY),
        .o_count    (w_count)
    );

    assign O     = w_rd_data[C_WIDTH+C_SW-1:C_SW];
    assign O_SRC = w_rd_data[C_SW-1:0];

endmodule

// File: tb/tb_tbus_sink_arbiter.sv
// tb/tb_tbus_sink_arbiter.sv - directed bench for tbus_sink_arbiter at turnaround 1, 0 and 3
module tb_tbus_sink_arbiter;

    logic        CLK = 1'b0;
    logic        ACLR_N = 1'b0;
    logic [3:0]  REQ = 4'h0;
    logic        O_READY = 1'b1;

    // index 0: turnaround 1, index 1: turnaround 0, index 2: turnaround 3
    logic [3:0]  oe   [3];
    logic [15:0] bus  [3];
    logic [15:0] o    [3];
    logic [1:0]  osrc [3];
    logic        ov   [3];
    logic [7:0]  wcnt [3][4];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0]  t2_oe1 [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [3:0]  t2_oe0 [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic        t2_ov  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  t2_src [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [15:0] t2_o   [9] = '{16'h0, 16'h1000, 16'h0, 16'h2000, 16'h0, 16'h3000, 16'h0, 16'h4000, 16'h0};
    logic [3:0]  t6_oe  [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h8};

    always #5 CLK = ~CLK;

    tbus_sink_arbiter #(.C_WIDTH(16), .C_NUM_SRC(4), .C_TURNAROUND(1)) u_ta1 (
        .CLK(CLK), .ACLR_N(ACLR_N), .REQ(REQ), .OE(oe[0]), .BUS(bus[0]),
        .O(o[0]), .O_SRC(osrc[0]), .O_VALID(ov[0]), .O_READY(O_READY));
    tbus_sink_arbiter #(.C_WIDTH(16), .C_NUM_SRC(4), .C_TURNAROUND(0)) u_ta0 (
        .CLK(CLK), .ACLR_N(ACLR_N), .REQ(REQ), .OE(oe[1]), .BUS(bus[1]),
        .O(o[1]), .O_SRC(osrc[1]), .O_VALID(ov[1]), .O_READY(O_READY));
    tbus_sink_arbiter #(.C_WIDTH(16), .C_NUM_SRC(4), .C_TURNAROUND(3)) u_ta3 (
        .CLK(CLK), .ACLR_N(ACLR_N), .REQ(REQ), .OE(oe[2]), .BUS(bus[2]),
        .O(o[2]), .O_SRC(osrc[2]), .O_VALID(ov[2]), .O_READY(O_READY));

    // Bus drivers: source s drives 0x1000*(s+1) + n for its n-th word, advancing when granted.
    always @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            for (int k = 0; k < 3; k++)
                for (int s = 0; s < 4; s++) wcnt[k][s] <= 8'h0;
        end else begin
            for (int k = 0; k < 3; k++)
                for (int s = 0; s < 4; s++)
                    if (oe[k][s]) wcnt[k][s] <= wcnt[k][s] + 8'h1;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bus[k] = 16'h0;
            for (int s = 0; s < 4; s++)
                if (oe[k][s]) bus[k] = bus[k] | {4'(s + 1), 4'h0, wcnt[k][s]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) check("oe_onehot0", 32'($onehot0(oe[k])), 32'd1);
    endtask

    task automatic do_reset(input logic [3:0] req, input logic rdy);
        ACLR_N  = 1'b0;
        REQ     = 4'h0;
        O_READY = 1'b1;
        step();
        step();
        ACLR_N  = 1'b1;
        REQ     = req;
        O_READY = rdy;
    endtask

    initial begin
        // Reset state and single-source streaming
        do_reset(4'h0, 1'b1);
        check("rst_oe", 32'(oe[0]), 32'h0);
        check("rst_ov", 32'(ov[0]), 32'h0);
        check("rst_o", 32'(o[0]), 32'h0);
        check("rst_src", 32'(osrc[0]), 32'h0);
        REQ = 4'b0001;
        step();
        check("t1_oe_c1", 32'(oe[0]), 32'h1);
        check("t1_ov_c1", 32'(ov[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_oe", 32'(oe[0]), 32'h1);
            check("t1_ov", 32'(ov[0]), 32'h1);
            check("t1_o", 32'(o[0]), 32'h1000 + 32'(i));
            check("t1_src", 32'(osrc[0]), 32'h0);
        end

        // All sources requesting: turnaround 1 vs turnaround 0
        do_reset(4'b1111, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("t2_oe_ta1", 32'(oe[0]), 32'(t2_oe1[i]));
            check("t2_oe_ta0", 32'(oe[1]), 32'(t2_oe0[i]));
            check("t2_ov_ta1", 32'(ov[0]), 32'(t2_ov[i]));
            if (t2_ov[i]) begin
                check("t2_src_ta1", 32'(osrc[0]), 32'(t2_src[i]));
                check("t2_o_ta1", 32'(o[0]), 32'(t2_o[i]));
            end
        end

        // Backpressure: two words fill the buffer, then granting stops
        do_reset(4'b0001, 1'b0);
        step();
        check("t3_oe_c1", 32'(oe[0]), 32'h1);
        step();
        check("t3_oe_c2", 32'(oe[0]), 32'h1);
        check("t3_o_c2", 32'(o[0]), 32'h1000);
        step();
        check("t3_oe_c3", 32'(oe[0]), 32'h0);
        step();
        check("t3_oe_c4", 32'(oe[0]), 32'h0);
        check("t3_ov_c4", 32'(ov[0]), 32'h1);
        check("t3_o_c4", 32'(o[0]), 32'h1000);
        O_READY = 1'b1;
        step();
        check("t3_oe_c5", 32'(oe[0]), 32'h1);
        check("t3_o_c5", 32'(o[0]), 32'h1001);
        step();
        check("t3_oe_c6", 32'(oe[0]), 32'h1);
        check("t3_o_c6", 32'(o[0]), 32'h1002);
        check("t3_ov_c6", 32'(ov[0]), 32'h1);

        // Asynchronous reset mid-transfer
        do_reset(4'b0100, 1'b1);
        step();
        check("t4_oe_c1", 32'(oe[0]), 32'h4);
        step();
        check("t4_oe_c2", 32'(oe[0]), 32'h4);
        check("t4_o_c2", 32'(o[0]), 32'h3000);
        check("t4_src_c2", 32'(osrc[0]), 32'h2);
        ACLR_N = 1'b0;
        #2;
        check("t4_async_oe", 32'(oe[0]), 32'h0);
        check("t4_async_ov", 32'(ov[0]), 32'h0);
        check("t4_async_o", 32'(o[0]), 32'h0);
        check("t4_async_src", 32'(osrc[0]), 32'h0);
        REQ = 4'b1111;
        step();
        ACLR_N = 1'b1;
        step();
        check("t4_first_grant", 32'(oe[0]), 32'h1);
        step();
        check("t4_turn_after", 32'(oe[0]), 32'h0);

        // Turnaround 0: alternating requests go back-to-back
        do_reset(4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_oe", 32'(oe[1]), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                check("t5_src", 32'(osrc[1]), 32'((i - 1) % 2));
                check("t5_o", 32'(o[1]), 32'h1000 * 32'(((i - 1) % 2) + 1) + 32'((i - 1) / 2));
            end
            REQ = (i % 2 == 0) ? 4'b0010 : 4'b0001;
        end

        // Turnaround 3: three dead cycles between different sources
        do_reset(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_oe", 32'(oe[2]), 32'(t6_oe[i]));
            if (i == 0) REQ = 4'b1000;
            if (i == 1) begin
                check("t6_o_first", 32'(o[2]), 32'h1000);
                check("t6_src_first", 32'(osrc[2]), 32'h0);
            end
        end
        step();
        check("t6_o_second", 32'(o[2]), 32'h4000);
        check("t6_src_second", 32'(osrc[2]), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
